// File: rtl/gpio_bank_pkg.sv
// Shared types and fixed register indices for the GPIO bank.
package gpio_bank_pkg;

  localparam int unsigned ADDR_W = 4;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_SET  = 2'b01,
    MODE_CLR  = 2'b10,
    MODE_TGL  = 2'b11
  } bus_mode_e;

  localparam logic [ADDR_W-1:0] ADDR_IN   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT0 = 4'd1;

endpackage

// File: rtl/gpio_in_cond.sv
// Input conditioning for the GPIO bank: 2-flop synchroniser, optional
// per-bit debouncer (GPIO_BANK_DEBOUNCE_EN) and a per-bit rise pulse.
// A bit only reports rises after it has been seen low since reset, so
// inputs already high when reset releases do not raise a spurious edge.
module gpio_in_cond
  import gpio_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] in_val,
  output logic [DATA_W-1:0] rise_c
);

  logic [DATA_W-1:0] sync1;
  logic [DATA_W-1:0] sync2;
  logic [1:0]        sync_vld;
  logic [DATA_W-1:0] in_prev;
  logic [DATA_W-1:0] armed;
  logic [DATA_W-1:0] commit_c;

  // Two-stage synchroniser; sync_vld marks when sync2 carries real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [DATA_W-1:0]            stable_ref;
  logic [DATA_W-1:0][CNT_W-1:0] cnt;
  logic [DATA_W-1:0]            deb_q;

  // Per-bit stability counter; restarts on any change of the synchronised bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_ref <= '0;
      cnt        <= '0;
      deb_q      <= '0;
    end else if (sync_vld[1]) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (sync2[i] != stable_ref[i]) begin
          stable_ref[i] <= sync2[i];
          cnt[i]        <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb_q[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A bit's conditioned value is confirmed once its counter has saturated.
  always_comb begin
    commit_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      commit_c[i] = sync_vld[1] && (sync2[i] == stable_ref[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign in_val = deb_q;
`else
  logic deb_unused;

  assign deb_unused = |DEB_CYCLES;
  assign in_val     = sync2;
  assign commit_c   = {DATA_W{sync_vld[1]}};
`endif

  // Track previous level and arm each bit once it is confirmed low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev <= '0;
      armed   <= '0;
    end else begin
      in_prev <= in_val;
      armed   <= armed | (commit_c & ~sync2);
    end
  end

  assign rise_c = in_val & ~in_prev & armed;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: register-mapped output channels with set/clear/toggle writes,
// conditioned switch inputs and a rise-edge level interrupt.
// Optional input debouncing is enabled by defining GPIO_BANK_DEBOUNCE_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic                    bus_wr,
  input  logic                    bus_rd,
  input  logic [1:0]              bus_mode,
  input  logic [DATA_W-1:0]       bus_wdata,
  output logic [DATA_W-1:0]       bus_rdata,
  output logic                    bus_rvalid,
  input  logic [DATA_W-1:0]       DIN_SW,
  output logic [N_OUT*DATA_W-1:0] DOUT,
  output logic                    irq
);

  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = ADDR_W'(N_OUT + 1);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = ADDR_W'(N_OUT + 2);

  logic [N_OUT-1:0][DATA_W-1:0] out_q;
  logic [N_OUT-1:0][DATA_W-1:0] out_d;
  logic [DATA_W-1:0]            irq_en;
  logic [DATA_W-1:0]            en_d;
  logic [DATA_W-1:0]            irq_stat;
  logic [DATA_W-1:0]            stat_d;
  logic [DATA_W-1:0]            w1c;
  logic [DATA_W-1:0]            rd_mux;
  logic [DATA_W-1:0]            in_val;
  logic [DATA_W-1:0]            rise_c;

  function automatic logic [DATA_W-1:0] apply_mode(
    input bus_mode_e         mode,
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] res;
    case (mode)
      MODE_SET: res = cur | wd;
      MODE_CLR: res = cur & ~wd;
      MODE_TGL: res = cur ^ wd;
      default:  res = wd;
    endcase
    return res;
  endfunction

  gpio_in_cond #(
    .DATA_W     (DATA_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_in_cond (
    .clk    (CLK),
    .rst_n  (RST_n),
    .din    (DIN_SW),
    .in_val (in_val),
    .rise_c (rise_c)
  );

  // Next register values from bus writes and input edges; a new edge beats W1C.
  always_comb begin
    out_d = out_q;
    en_d  = irq_en;
    w1c   = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (bus_wr && (bus_addr == ADDR_OUT0 + ADDR_W'(k))) begin
        out_d[k] = apply_mode(bus_mode_e'(bus_mode), out_q[k], bus_wdata);
      end
    end
    if (bus_wr && (bus_addr == ADDR_IRQ_EN)) begin
      en_d = bus_wdata;
    end
    if (bus_wr && (bus_addr == ADDR_IRQ_STAT)) begin
      w1c = bus_wdata;
    end
    stat_d = (irq_stat & ~w1c) | (rise_c & irq_en);
  end

  // Read mux over current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    if (bus_addr == ADDR_IN) begin
      rd_mux = in_val;
    end
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (bus_addr == ADDR_OUT0 + ADDR_W'(k)) begin
        rd_mux = out_q[k];
      end
    end
    if (bus_addr == ADDR_IRQ_EN) begin
      rd_mux = irq_en;
    end
    if (bus_addr == ADDR_IRQ_STAT) begin
      rd_mux = irq_stat;
    end
  end

  // Control/status registers and the registered interrupt level.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      out_q    <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      out_q    <= out_d;
      irq_en   <= en_d;
      irq_stat <= stat_d;
      irq      <= |(stat_d & en_d);
    end
  end

  // One-cycle read response; data holds until the next read.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_rd;
      if (bus_rd) begin
        bus_rdata <= rd_mux;
      end
    end
  end

  assign DOUT = out_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank; read responses go through a scoreboard
// queue filled when a read is issued and drained when bus_rvalid appears.
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned N_OUT      = 2;
  localparam int unsigned DEB_CYCLES = 16;
`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int SETTLE = DEB_CYCLES + 8;
`else
  localparam int SETTLE = 5;
`endif

  logic                    CLK = 1'b0;
  logic                    RST_n = 1'b0;
  logic [3:0]              bus_addr = '0;
  logic                    bus_wr = 1'b0;
  logic                    bus_rd = 1'b0;
  logic [1:0]              bus_mode = '0;
  logic [DATA_W-1:0]       bus_wdata = '0;
  logic [DATA_W-1:0]       bus_rdata;
  logic                    bus_rvalid;
  logic [DATA_W-1:0]       DIN_SW = '0;
  logic [N_OUT*DATA_W-1:0] DOUT;
  logic                    irq;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
    string             tag;
  } rd_exp_t;

  rd_exp_t rq[$];
  rd_exp_t mon_e;
  logic    exp_v;
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;

  gpio_bank #(
    .DATA_W     (DATA_W),
    .N_OUT      (N_OUT),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_mode   (bus_mode),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .DIN_SW     (DIN_SW),
    .DOUT       (DOUT),
    .irq        (irq)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Read scoreboard: response must arrive exactly on the due cycle.
  always @(negedge CLK) begin
    exp_v = (rq.size() != 0) && (rq[0].due == cyc);
    if (bus_rvalid || exp_v) begin
      check("rvalid", 64'(bus_rvalid), 64'(exp_v));
      if (exp_v) begin
        mon_e = rq.pop_front();
        check(mon_e.tag, 64'(bus_rdata), 64'(mon_e.data));
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [1:0] m, input logic [DATA_W-1:0] d);
    @(posedge CLK); #1;
    bus_addr = a; bus_mode = m; bus_wdata = d; bus_wr = 1'b1;
    @(posedge CLK); #1;
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [DATA_W-1:0] exp, input string tag);
    rd_exp_t e;
    @(posedge CLK); #1;
    bus_addr = a; bus_rd = 1'b1;
    e.data = exp; e.due = cyc + 1; e.tag = tag;
    rq.push_back(e);
    @(posedge CLK); #1;
    bus_rd = 1'b0;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [1:0] m, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] exp, input string tag);
    rd_exp_t e;
    @(posedge CLK); #1;
    bus_addr = a; bus_mode = m; bus_wdata = d; bus_wr = 1'b1; bus_rd = 1'b1;
    e.data = exp; e.due = cyc + 1; e.tag = tag;
    rq.push_back(e);
    @(posedge CLK); #1;
    bus_wr = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic check_ch(input string tag, input int ch, input logic [DATA_W-1:0] exp);
    @(negedge CLK);
    check(tag, 64'(DOUT[ch*DATA_W +: DATA_W]), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #2;
    check("rst_dout", 64'(DOUT), 64'h0);
    check("rst_rvalid", 64'(bus_rvalid), 64'h0);
    check("rst_rdata", 64'(bus_rdata), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    @(negedge CLK); #1;
    RST_n = 1'b1;
    wait_cyc(SETTLE + 4);

    // Write modes on channel 0
    bus_write(4'd1, MODE_LOAD, 16'h00FF); check_ch("out0_load", 0, 16'h00FF);
    bus_write(4'd1, MODE_SET,  16'hF000); check_ch("out0_set",  0, 16'hF0FF);
    bus_write(4'd1, MODE_CLR,  16'h000F); check_ch("out0_clr",  0, 16'hF0F0);
    bus_write(4'd1, MODE_TGL,  16'hFFFF); check_ch("out0_tgl",  0, 16'h0F0F);
    check("out1_idle", 64'(DOUT[31:16]), 64'h0);

    // Reads, unmapped addresses, read-only IN
    bus_write(4'd2, MODE_LOAD, 16'h1234); check_ch("out1_load", 1, 16'h1234);
    bus_read(4'd2, 16'h1234, "rd_out1");
    bus_read(4'hF, 16'h0000, "rd_unmapped");
    bus_read(4'd1, 16'h0F0F, "rd_out0");
    bus_write(4'hF, MODE_LOAD, 16'hFFFF);
    bus_write(4'd5, MODE_LOAD, 16'hFFFF);
    bus_write(4'd0, MODE_LOAD, 16'hFFFF);
    @(negedge CLK);
    check("dout_after_bad_wr", 64'(DOUT), 64'h1234_0F0F);
    bus_read(4'd0, 16'h0000, "rd_in_zero");
    bus_read(4'd5, 16'h0000, "rd_addr5");

    // Simultaneous read and write returns the old value
    bus_rw(4'd1, MODE_LOAD, 16'h5555, 16'h0F0F, "rd_rw_prewrite");
    check_ch("out0_rw_post", 0, 16'h5555);

    // IRQ_EN ignores bus_mode
    bus_write(4'd3, MODE_LOAD, 16'h00F0);
    bus_write(4'd3, MODE_CLR,  16'h0001);
    bus_read(4'd3, 16'h0001, "rd_irq_en");

    // Rise on bits 0 and 1; only bit 0 enabled
    @(posedge CLK); #1; DIN_SW = 16'h0003;
    wait_cyc(SETTLE);
    @(negedge CLK);
    check("irq_rise", 64'(irq), 64'h1);
    bus_read(4'd4, 16'h0001, "rd_stat_rise");
    bus_read(4'd0, 16'h0003, "rd_in_high");
    bus_write(4'd4, MODE_TGL, 16'h0001);
    @(posedge CLK); @(negedge CLK);
    check("irq_w1c", 64'(irq), 64'h0);
    bus_read(4'd4, 16'h0000, "rd_stat_w1c");

`ifndef GPIO_BANK_DEBOUNCE_EN
    // W1C in the same cycle as a fresh rise: set wins
    @(posedge CLK); #1; DIN_SW = 16'h0002;
    wait_cyc(SETTLE);
    @(posedge CLK); #1; DIN_SW = 16'h0003;
    @(posedge CLK);
    @(posedge CLK); #1;
    bus_addr = 4'd4; bus_mode = MODE_LOAD; bus_wdata = 16'h0001; bus_wr = 1'b1;
    @(posedge CLK); #1;
    bus_wr = 1'b0;
    @(negedge CLK);
    check("irq_collide", 64'(irq), 64'h1);
    bus_read(4'd4, 16'h0001, "rd_stat_collide");
    bus_write(4'd4, MODE_LOAD, 16'h0001);
`else
    // Short glitch is filtered, a long level is accepted
    bus_write(4'd3, MODE_LOAD, 16'h0009);
    @(posedge CLK); #1; DIN_SW = 16'h000B;
    wait_cyc(5);
    #1; DIN_SW = 16'h0003;
    wait_cyc(SETTLE);
    bus_read(4'd0, 16'h0003, "rd_in_glitch");
    bus_read(4'd4, 16'h0000, "rd_stat_glitch");
    @(negedge CLK);
    check("irq_glitch", 64'(irq), 64'h0);
    @(posedge CLK); #1; DIN_SW = 16'h000B;
    wait_cyc(22);
    bus_read(4'd0, 16'h000B, "rd_in_level");
    bus_read(4'd4, 16'h0008, "rd_stat_level");
    bus_write(4'd4, MODE_LOAD, 16'h0008);
    bus_write(4'd3, MODE_LOAD, 16'h0001);
`endif

    // Asynchronous reset mid-cycle, with bit 2 held high through it
    @(posedge CLK); #1; DIN_SW = 16'h0004;
    wait_cyc(SETTLE);
    bus_write(4'd1, MODE_LOAD, 16'hABCD); check_ch("out0_abcd", 0, 16'hABCD);
    #2; RST_n = 1'b0;
    #1;
    check("async_rst_dout", 64'(DOUT), 64'h0);
    check("async_rst_irq", 64'(irq), 64'h0);
    check("async_rst_rdata", 64'(bus_rdata), 64'h0);
    wait_cyc(2);
    @(negedge CLK); #1;
    RST_n = 1'b1;
    bus_addr = 4'd3; bus_mode = MODE_LOAD; bus_wdata = 16'h0004; bus_wr = 1'b1;
    @(posedge CLK); #1;
    bus_wr = 1'b0;
    wait_cyc(SETTLE + 4);
    @(negedge CLK);
    check("irq_no_edge_after_rst", 64'(irq), 64'h0);
    bus_read(4'd4, 16'h0000, "rd_stat_no_edge");
    bus_read(4'd0, 16'h0004, "rd_in_held");
    bus_read(4'd3, 16'h0004, "rd_en_after_rst");
    @(posedge CLK); #1; DIN_SW = 16'h0000;
    wait_cyc(SETTLE);
    @(posedge CLK); #1; DIN_SW = 16'h0004;
    wait_cyc(SETTLE);
    @(negedge CLK);
    check("irq_first_real_edge", 64'(irq), 64'h1);
    bus_read(4'd4, 16'h0004, "rd_stat_real_edge");

    wait_cyc(3);
    check("rd_queue_empty", 64'(rq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
